// File: rtl/parity_generator_checker_if.sv
// Bus bundle for parity_generator_checker: beat inputs, registered outputs and error status.
// err_count exists only when PGC_ERR_COUNT_EN is defined.
interface parity_generator_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] data_in;
    logic             parity_in;
    logic             odd_sel;
    logic             clr_sticky;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             parity_out;
    logic             error;
    logic             err_sticky;
`ifdef PGC_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, data_in, parity_in, odd_sel, clr_sticky,
        output out_valid, data_out, parity_out, error, err_sticky, err_count
    );
    modport master (
        output in_valid, data_in, parity_in, odd_sel, clr_sticky,
        input  out_valid, data_out, parity_out, error, err_sticky, err_count
    );
`else
    modport slave (
        input  in_valid, data_in, parity_in, odd_sel, clr_sticky,
        output out_valid, data_out, parity_out, error, err_sticky
    );
    modport master (
        output in_valid, data_in, parity_in, odd_sel, clr_sticky,
        input  out_valid, data_out, parity_out, error, err_sticky
    );
`endif
endinterface

// File: rtl/parity_generator_checker.sv
// Registered parity generator/checker with sticky error status.
// Define PGC_ERR_COUNT_EN to add the saturating err_count counter.
module parity_generator_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    parity_generator_checker_if.slave  bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("parity_generator_checker: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("parity_generator_checker: CNT_W must be >= 1");
    end

    logic             gen;
    logic             chk;
    logic             err_set;

    logic             out_valid_q;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             parity_q, parity_d;
    logic             error_q;
    logic             sticky_q, sticky_d;

    always_comb begin
        gen     = (^bus.data_in) ^ bus.odd_sel;
        chk     = gen ^ bus.parity_in;
        err_set = bus.in_valid & chk;
    end

    // Data and generated parity hold their last value across idle cycles.
    always_comb begin
        data_d   = data_q;
        parity_d = parity_q;
        if (bus.in_valid) begin
            data_d   = bus.data_in;
            parity_d = gen;
        end
    end

    // A new error outranks a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (err_set)
            sticky_d = 1'b1;
        else if (bus.clr_sticky)
            sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            error_q     <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            data_q      <= data_d;
            parity_q    <= parity_d;
            error_q     <= err_set;
            sticky_q    <= sticky_d;
        end
    end

`ifdef PGC_ERR_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear and error together restart the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_sticky)
            cnt_d = err_set ? CNT_W'(1) : '0;
        else if (err_set && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.err_count = cnt_q;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.parity_out = parity_q;
    assign bus.error      = error_q;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_generator_checker.sv
// Directed plus randomized bench for parity_generator_checker against a ones-counting model.
module tb_parity_generator_checker;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_generator_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    parity_generator_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs must show after each edge.
    logic             m_valid  = 1'b0;
    logic [WIDTH-1:0] m_data   = '0;
    logic             m_par    = 1'b0;
    logic             m_err    = 1'b0;
    logic             m_sticky = 1'b0;
    int               m_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  32'(bus.out_valid),  32'(m_valid));
        check({tag, ".data_out"},   32'(bus.data_out),   32'(m_data));
        check({tag, ".parity_out"}, 32'(bus.parity_out), 32'(m_par));
        check({tag, ".error"},      32'(bus.error),      32'(m_err));
        check({tag, ".err_sticky"}, 32'(bus.err_sticky), 32'(m_sticky));
`ifdef PGC_ERR_COUNT_EN
        check({tag, ".err_count"},  32'(bus.err_count),  32'(m_cnt));
`endif
    endtask

    // Drive one cycle, advance the model from the parity rules, then compare.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [WIDTH-1:0] d, input logic p, input logic o,
                        input logic c);
        int  ones;
        bit  e;
        rst            = r;
        bus.in_valid   = v;
        bus.data_in    = d;
        bus.parity_in  = p;
        bus.odd_sel    = o;
        bus.clr_sticky = c;
        @(posedge clk);
        ones = $countones(d);
        if (r) begin
            m_valid = 0; m_data = '0; m_par = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            // Received parity is wrong when data+parity ones parity differs from the mode.
            e = v && (((ones + int'(p)) % 2) != int'(o));
            m_valid = v;
            m_err   = e;
            if (v) begin
                m_data = d;
                m_par  = ((ones + int'(o)) % 2) == 1;
            end
            if (e)      m_sticky = 1;
            else if (c) m_sticky = 0;
            if (c)      m_cnt = e ? 1 : 0;
            else if (e) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        // Reset while a beat is offered: it must be discarded.
        step("rst0", 1, 1, 8'hFF, 1, 0, 0);
        step("rst1", 1, 1, 8'hFF, 1, 0, 0);
        check("rst.out_valid_const", 32'(bus.out_valid), 32'd0);
        check("rst.data_const",      32'(bus.data_out),   32'd0);

        step("even55", 0, 1, 8'h55, 0, 0, 0);
        check("even55.par_const", 32'(bus.parity_out), 32'd0);
        check("even55.err_const", 32'(bus.error),      32'd0);
        step("even57", 0, 1, 8'h57, 0, 0, 0);
        check("even57.par_const",    32'(bus.parity_out), 32'd1);
        check("even57.err_const",    32'(bus.error),      32'd1);
        check("even57.sticky_const", 32'(bus.err_sticky), 32'd1);

        step("oddF0", 0, 1, 8'hF0, 1, 1, 0);
        check("oddF0.par_const", 32'(bus.parity_out), 32'd1);
        check("oddF0.err_const", 32'(bus.error),      32'd0);
        step("odd0F", 0, 1, 8'h0F, 0, 1, 0);
        check("odd0F.err_const", 32'(bus.error), 32'd1);

        step("beatAA", 0, 1, 8'hAA, 0, 0, 0);
        step("idle1",  0, 0, 8'h13, 1, 1, 0);
        check("idle1.data_const", 32'(bus.data_out),   32'hAA);
        check("idle1.par_const",  32'(bus.parity_out), 32'd0);
        step("idle2",  0, 0, 8'hFE, 0, 0, 0);

        step("clr_only",  0, 1, 8'h03, 0, 0, 1);
        check("clr_only.sticky_const", 32'(bus.err_sticky), 32'd0);
        step("clr_and_err", 0, 1, 8'h01, 0, 0, 1);
        check("clr_and_err.sticky_const", 32'(bus.err_sticky), 32'd1);

        // Mid-stream reset drops the registered beat.
        step("pre_rst", 0, 1, 8'h81, 1, 0, 0);
        step("mid_rst", 1, 1, 8'h7E, 1, 1, 1);
        step("post_rst", 0, 1, 8'hC3, 0, 1, 0);

        // Long error run: count must saturate; then clear with a clean beat.
        for (int i = 0; i < 300; i++) begin
            rd = WIDTH'($urandom);
            step("err_run", 0, 1, rd, ~(^rd), 0, 0);
        end
`ifdef PGC_ERR_COUNT_EN
        check("err_run.count_const", 32'(bus.err_count), 32'd255);
`endif
        step("clr_clean", 0, 1, 8'h00, 0, 0, 1);
`ifdef PGC_ERR_COUNT_EN
        check("clr_clean.count_const", 32'(bus.err_count), 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
                 WIDTH'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_generator_checker.md
# parity_generator_checker

Registered, single-clock parity generator and checker for a WIDTH-bit data word. Each accepted beat produces the generated parity bit for the word. It also checks the received parity bit against the word and flags a mismatch. Accumulated error status is kept for link or bus monitoring. The block sits between a data source/sink and status logic; its outputs are one register stage after its inputs.

## Interface
- WIDTH, 8, data word width in bits (≥ 1)
- CNT_W, 8, error counter width (used only with PGC_ERR_COUNT_EN)

- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  data_in/parity_in/odd_sel qualify this cycle
- data_in  input  WIDTH  data word to protect/check
- parity_in  input  1  received parity bit accompanying data_in
- odd_sel  input  1  0 = even parity, 1 = odd parity (sampled per beat)
- clr_sticky  input  1  clears err_sticky (and err_count when compiled in)
- out_valid  output  1  registered copy of in_valid
- data_out  output  WIDTH  registered data_in
- parity_out  output  1  generated parity for the registered word
- error  output  1  parity mismatch for the registered beat
- err_sticky  output  1  latched "any error since last clear"
- err_count  output  CNT_W  saturating error count (only with PGC_ERR_COUNT_EN)

## Operation
- Let x = XOR-reduction of data_in.
- gen = x ^ odd_sel.
  - Even mode: total ones in {data, gen} is even.
  - Odd mode: total ones in {data, gen} is odd.
- chk = gen ^ parity_in, which equals x ^ parity_in ^ odd_sel. chk = 1 means the received parity is wrong for the selected mode.
- Beat accepted (in_valid = 1): on the next edge, register data_out ← data_in, parity_out ← gen, error ← chk, out_valid ← 1.
- No beat (in_valid = 0):
  - out_valid ← 0 and error ← 0.
  - data_out and parity_out hold their last values.
- err_sticky, evaluated on the same edge that registers the beat:
  - Set when an accepted beat has chk = 1.
  - Cleared when clr_sticky = 1.
  - If set and clear occur in the same cycle, set wins (err_sticky = 1).
- Pure combinational function per beat: no dependence on previous beats except the sticky/count status.
- odd_sel may change on any beat. It takes effect for that beat only.

## Timing
- Latency: 1 clock from in_valid/data_in to out_valid/data_out/parity_out/error.
- Throughput: one beat per clock, with no back-pressure.
- err_sticky and err_count update on the same edge that registers error, so they are visible together with that error.
- Reset (rst = 1 at a rising edge) forces all outputs and state to 0:
  - out_valid, data_out, parity_out, error, err_sticky, err_count.
  - A beat presented during reset is discarded.
  - The first beat after reset deasserts is accepted normally.
- Reset asserted mid-stream drops the in-flight registered beat. out_valid is 0 on the cycle after reset.
- rst has priority over in_valid and clr_sticky.

## Configuration
- PGC_ERR_COUNT_EN defined:
  - err_count port and counter exist.
  - Count increments by 1 on each accepted beat with chk = 1 and saturates at 2^CNT_W − 1.
  - clr_sticky zeroes the count.
  - Clear and error in the same cycle: the count becomes 1.
- PGC_ERR_COUNT_EN undefined: no err_count port and no counter logic. All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles while driving in_valid = 1, data_in = 0xFF -> all outputs 0 the cycle after reset; out_valid = 0.
- Even mode: in_valid = 1, odd_sel = 0, data_in = 0x55, parity_in = 0 -> next cycle out_valid = 1, data_out = 0x55, parity_out = 0, error = 0. Then data_in = 0x57, parity_in = 0 -> parity_out = 1, error = 1, err_sticky = 1.
- Odd mode: odd_sel = 1, data_in = 0xF0, parity_in = 1 -> parity_out = 1, error = 0. Then data_in = 0x0F, parity_in = 0 -> error = 1.
- Idle hold: after beat 0xAA (even, parity_in 0), drop in_valid -> out_valid = 0, error = 0, data_out stays 0xAA, parity_out stays 0.
- Sticky priority:
  - clr_sticky = 1 with no error beat -> err_sticky = 0.
  - clr_sticky = 1 in the same cycle as an erroring beat (0x01, even, parity_in 0) -> err_sticky = 1.
- With PGC_ERR_COUNT_EN, CNT_W = 8: 300 consecutive erroring beats -> err_count = 255. Then clr_sticky with a non-erroring beat -> err_count = 0.
